// File: rtl/audio_clkgen_if.sv
// Control/status bundle for audio_clkgen: run enable and increment reload in,
// phase-locked MCLK/SCLK/LRCK and strobes out.
interface audio_clkgen_if #(
    parameter int unsigned ACC_W = 32
);
    logic             en;
    logic [ACC_W-1:0] inc_in;
    logic             inc_load;
    logic             mclk;
    logic             mclk_tick;
    logic             sclk;
    logic             lrck;
    logic             frame_start;
    logic             reload_pending;

    modport master (
        output en, inc_in, inc_load,
        input  mclk, mclk_tick, sclk, lrck, frame_start, reload_pending
    );

    modport slave (
        input  en, inc_in, inc_load,
        output mclk, mclk_tick, sclk, lrck, frame_start, reload_pending
    );
endinterface

// File: rtl/audio_clkgen.sv
// NCO-based audio clock generator: MCLK from a phase accumulator, SCLK/LRCK from an MCLK-edge counter.
// Define AUDIO_CLKGEN_RELOAD_EN to enable frame-aligned runtime reload of the phase increment.
module audio_clkgen #(
    parameter int unsigned ACC_W         = 32,
    parameter longint unsigned INC_RST   = 64'd527765581,
    parameter int unsigned MCLK_PER_SCLK = 4,
    parameter int unsigned SCLK_PER_LR   = 64
) (
    input logic           clk,
    input logic           rst,
    audio_clkgen_if.slave bus
);
    localparam int unsigned FRAME = MCLK_PER_SCLK * SCLK_PER_LR;
    localparam int unsigned MW    = $clog2(FRAME);
    localparam int unsigned SW    = $clog2(MCLK_PER_SCLK);
    localparam logic [ACC_W-1:0] INC_INIT  = ACC_W'(INC_RST);
    localparam logic [MW-1:0]    MCNT_LAST = MW'(FRAME - 1);

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum, inc_q;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             tick_q, tick_d, fs_q, fs_d, tick;

    // FRAME is a power of two, so the counter wraps to 0 on its own.
    always_comb begin
        acc_sum = acc_q + inc_q;
        tick    = ~acc_q[ACC_W-1] & acc_sum[ACC_W-1];
        acc_d   = acc_q;
        mcnt_d  = mcnt_q;
        tick_d  = 1'b0;
        fs_d    = 1'b0;
        if (bus.en) begin
            acc_d  = acc_sum;
            tick_d = tick;
            fs_d   = tick & (mcnt_q == MCNT_LAST);
            if (tick) begin
                mcnt_d = mcnt_q + MW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            mcnt_q <= '0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mcnt_q <= mcnt_d;
            tick_q <= tick_d;
            fs_q   <= fs_d;
        end
    end

`ifdef AUDIO_CLKGEN_RELOAD_EN
    logic [ACC_W-1:0] inc_d, pend_q, pend_d;
    logic             pendv_q, pendv_d, load_ok;

    // The wrap consumes the older pending value; a load on the same edge refills it for the next wrap.
    always_comb begin
        load_ok = bus.en & bus.inc_load & ~bus.inc_in[ACC_W-1];
        inc_d   = inc_q;
        pend_d  = pend_q;
        pendv_d = pendv_q;
        if (fs_d && pendv_q) begin
            inc_d   = pend_q;
            pendv_d = 1'b0;
        end
        if (load_ok) begin
            pend_d  = bus.inc_in;
            pendv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q   <= INC_INIT;
            pend_q  <= '0;
            pendv_q <= 1'b0;
        end else begin
            inc_q   <= inc_d;
            pend_q  <= pend_d;
            pendv_q <= pendv_d;
        end
    end

    assign bus.reload_pending = pendv_q;
`else
    logic inc_unused;

    assign inc_q              = INC_INIT;
    assign inc_unused         = ^{bus.inc_in, bus.inc_load};
    assign bus.reload_pending = 1'b0;
`endif

    assign bus.mclk        = acc_q[ACC_W-1];
    assign bus.mclk_tick   = tick_q;
    assign bus.sclk        = mcnt_q[SW-1];
    assign bus.lrck        = mcnt_q[MW-1];
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_audio_clkgen.sv
// Self-checking bench for audio_clkgen: reset table, rate, enable, reload and randomized traffic
// compared against a tick-counting reference model.
module tb_audio_clkgen;
    localparam int unsigned     MPS     = 4;
    localparam int unsigned     SPL     = 64;
    localparam int unsigned     FRAME   = MPS * SPL;
    localparam longint unsigned INC_RST = 64'd527765581;
    localparam longint unsigned HALF    = 64'h8000_0000;
    localparam longint unsigned MODV    = 64'h1_0000_0000;

    logic clk;
    logic rst;
    audio_clkgen_if #(.ACC_W(32)) bus();

    audio_clkgen #(
        .ACC_W(32), .INC_RST(INC_RST), .MCLK_PER_SCLK(MPS), .SCLK_PER_LR(SPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cycleNo  = 0;

    // Reference model: absolute phase plus a running count of MCLK rising edges.
    longint unsigned mPhase, mInc, mPend;
    bit              mPendValid, mTickOut, mFsOut;
    int unsigned     mTicks;

    typedef struct {
        bit         en;
        logic [5:0] expOut;
    } vec_t;
    vec_t resetTable [14];

    task automatic modelReset();
        mPhase = 0; mInc = INC_RST; mPend = 0; mPendValid = 0;
        mTicks = 0; mTickOut = 0; mFsOut = 0;
    endtask

    function automatic bit modelWrapNext();
        longint unsigned np = (mPhase + mInc) % MODV;
        return (mPhase < HALF) && (np >= HALF) && ((mTicks % FRAME) == FRAME - 1);
    endfunction

    task automatic modelStep(input bit e, input logic [31:0] incIn, input bit ld);
        longint unsigned np;
        bit tk, wr;
        if (!e) begin
            mTickOut = 0; mFsOut = 0;
            return;
        end
        np = (mPhase + mInc) % MODV;
        tk = (mPhase < HALF) && (np >= HALF);
        wr = tk && ((mTicks % FRAME) == FRAME - 1);
`ifdef AUDIO_CLKGEN_RELOAD_EN
        if (wr && mPendValid) begin
            mInc = mPend; mPendValid = 0;
        end
        if (ld && ({32'd0, incIn} < HALF)) begin
            mPend = {32'd0, incIn}; mPendValid = 1;
        end
`endif
        mPhase = np;
        if (tk) mTicks++;
        mTickOut = tk;
        mFsOut   = wr;
    endtask

    function automatic logic [5:0] modelVec();
        int unsigned m = mTicks % FRAME;
        return {mPhase >= HALF, mTickOut, ((m / (MPS / 2)) % 2) == 1,
                (m / (FRAME / 2)) == 1, mFsOut, mPendValid};
    endfunction

    function automatic logic [5:0] dutVec();
        return {bus.mclk, bus.mclk_tick, bus.sclk, bus.lrck, bus.frame_start, bus.reload_pending};
    endfunction

    task automatic applyStimulus(input bit e, input logic [31:0] incIn, input bit ld);
        @(negedge clk);
        bus.en = e; bus.inc_in = incIn; bus.inc_load = ld;
        @(posedge clk);
        modelStep(e, incIn, ld);
        cycleNo++;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expv);
        checks++;
        if (dutVec() !== expv) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got {mclk,tick,sclk,lrck,fs,pend}=%b want %b",
                     name, cycleNo, dutVec(), expv);
        end
    endtask

    task automatic checkValue(input string name, input longint got, input longint lo, input longint hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic cycle(input bit e, input logic [31:0] incIn, input bit ld);
        applyStimulus(e, incIn, ld);
        checkOutput("model", modelVec());
    endtask

    task automatic waitFrame(output int unsigned n);
        n = 0;
        for (int i = 0; i < 6000; i++) begin
            cycle(1'b1, 32'd0, 1'b0);
            n++;
            if (bus.frame_start) return;
        end
        checks++; failures++;
        $display("[TB] FAIL frameTimeout: got no frame_start in 6000 cycles, want one");
    endtask

    task automatic runResetTable();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(resetTable[i].en, 32'd0, 1'b0);
            checkOutput($sformatf("resetTable[%0d]", i), resetTable[i].expOut);
            checkOutput("model", modelVec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned n, tickCnt, fsCnt, fsBad, sclkTog, lrckTog, trans, ev;
        bit prevSclk, prevLrck, prevMclk, found;
        longint unsigned lo;

        for (int i = 0; i < 14; i++) resetTable[i] = '{1'b1, 6'b000000};
        resetTable[4]  = '{1'b1, 6'b110000};
        resetTable[5]  = '{1'b1, 6'b100000};
        resetTable[6]  = '{1'b1, 6'b100000};
        resetTable[7]  = '{1'b1, 6'b100000};
        resetTable[9]  = '{1'b0, 6'b000000};
        resetTable[13] = '{1'b1, 6'b111000};

        bus.en = 1'b0; bus.inc_in = '0; bus.inc_load = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetState", 6'b000000);
        rst = 1'b0;
        modelReset();

        // Rate from reset
        tickCnt = 0; fsCnt = 0; fsBad = 0; sclkTog = 0; lrckTog = 0;
        prevSclk = 0; prevLrck = 0;
        for (int i = 0; i < 12000; i++) begin
            cycle(1'b1, 32'd0, 1'b0);
            if (bus.mclk_tick) tickCnt++;
            if (bus.frame_start) begin
                fsCnt++;
                if (!(prevLrck && !bus.lrck)) fsBad++;
            end
            if (bus.sclk != prevSclk) sclkTog++;
            if (bus.lrck != prevLrck) lrckTog++;
            prevSclk = bus.sclk; prevLrck = bus.lrck;
        end
        lo = (64'd12000 * INC_RST) / MODV;
        checkValue("rateTicks", tickCnt, lo, lo + 1);
        checkValue("sclkToggles", sclkTog, mTicks / 2, mTicks / 2);
        checkValue("lrckToggles", lrckTog, mTicks / 128, mTicks / 128);
        checkValue("frameStarts", fsCnt, mTicks / FRAME, mTicks / FRAME);
        checkValue("fsOnLrckFall", fsBad, 0, 0);

        // Asynchronous reset mid-frame
        repeat (300) cycle(1'b1, 32'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", 6'b000000);
        rst = 1'b0;
        modelReset();
        runResetTable();

        // Enable gap mid-frame
        repeat (500) cycle(1'b1, 32'd0, 1'b0);
        ev = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 32'd0, 1'b0);
            if (bus.mclk_tick || bus.frame_start) ev++;
        end
        checkValue("enGapPulses", ev, 0, 0);
        repeat (40) cycle(1'b1, 32'd0, 1'b0);

`ifdef AUDIO_CLKGEN_RELOAD_EN
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle(1'b1, 32'd0, 1'b0);
            if (mTickOut && (mTicks % FRAME) == 37) found = 1;
        end
        checkValue("reachMcnt37", found, 1, 1);
        cycle(1'b1, 32'h4000_0000, 1'b1);
        checkValue("loadPending", bus.reload_pending, 1, 1);
        waitFrame(n);
        checkValue("pendCleared", bus.reload_pending, 0, 0);
        trans = 0; prevMclk = bus.mclk;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'd0, 1'b0);
            if (bus.mclk != prevMclk) trans++;
            prevMclk = bus.mclk;
        end
        checkValue("mclkEvery2", trans, 8, 8);

        cycle(1'b1, 32'd300000000, 1'b1);
        repeat (3) cycle(1'b1, 32'd0, 1'b0);
        cycle(1'b1, 32'd400000000, 1'b1);
        waitFrame(n);
        waitFrame(n);
        checkValue("lastLoadWins", n, 2747, 2750);

        cycle(1'b1, 32'h9000_0000, 1'b1);
        checkValue("invalidIgnored", bus.reload_pending, 0, 0);

        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (modelWrapNext()) found = 1;
            else cycle(1'b1, 32'd0, 1'b0);
        end
        checkValue("reachWrap", found, 1, 1);
        cycle(1'b1, 32'h2000_0000, 1'b1);
        checkValue("simulFrameStart", bus.frame_start, 1, 1);
        checkValue("simulPending", bus.reload_pending, 1, 1);
        waitFrame(n);
        checkValue("simulNotThisWrap", n, 2747, 2750);
        waitFrame(n);
        checkValue("simulNextWrap", n, 2047, 2049);
`else
        cycle(1'b1, 32'h4000_0000, 1'b1);
        checkValue("noReloadPending", bus.reload_pending, 0, 0);
        waitFrame(n);
        waitFrame(n);
        checkValue("rateUnchanged", n, 2082, 2085);
`endif

        // Randomized enable and loads against the model
        for (int i = 0; i < 3000; i++) begin
            bit e, ld;
            logic [31:0] v;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) v = $urandom | 32'h8000_0000;
            else v = $urandom_range(32'h7fff_ffff, 32'h1000_0000);
            cycle(e, v, ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_clkgen.md
# audio_clkgen

Parametrised audio clock generator for the codec interface. It produces a fractional-rate master clock (MCLK), a bit clock (SCLK) and a left/right frame clock (LRCK) from the single system clock. MCLK comes from a phase-accumulator NCO. SCLK and LRCK come from a shared MCLK-edge counter, so all three stay phase-locked. It sits between the system clock and the I2S serialiser, and supplies its frame strobe.

## Interface

- ACC_W, 32: accumulator width in bits.
- INC_RST, 527765581: phase increment after reset. At 100 MHz this gives 12.288 MHz MCLK (INC/2^ACC_W × f_clk).
- MCLK_PER_SCLK, 4: MCLK periods per SCLK period. Power of two, ≥2.
- SCLK_PER_LR, 64: SCLK periods per LRCK frame. Power of two, ≥2.

Ports:

- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset. Asynchronous, active-high.
- en  in  1  run enable. Low freezes all state.
- inc_in  in  ACC_W  new phase increment.
- inc_load  in  1  one-cycle strobe that captures inc_in.
- mclk  out  1  master clock.
- mclk_tick  out  1  one-cycle pulse on each MCLK rising edge.
- sclk  out  1  bit clock.
- lrck  out  1  frame clock. 0 = left half, 1 = right half.
- frame_start  out  1  one-cycle pulse at each frame wrap.
- reload_pending  out  1  a captured increment is waiting to be applied.

## Operation

- FRAME = MCLK_PER_SCLK × SCLK_PER_LR. mcnt is a log2(FRAME)-bit counter of MCLK rising edges.
- Each clk with en=1: acc_next = acc + inc, modulo 2^ACC_W.
- tick = ~acc[ACC_W-1] & acc_next[ACC_W-1].
- On a tick: mcnt increments and wraps from FRAME-1 to 0.
- Outputs:
  - mclk = acc[ACC_W-1].
  - sclk = mcnt[log2(MCLK_PER_SCLK)-1].
  - lrck = mcnt[log2(FRAME)-1].
- frame_start = tick & (mcnt == FRAME-1), i.e. asserted on the wrap tick.
- With en=0: acc, mcnt, inc, pending and all outputs hold their values. mclk_tick and frame_start are forced to 0.
- inc = 0 is legal: MCLK stops at its current level.
- Increment reload, only when AUDIO_CLKGEN_RELOAD_EN is defined:
  - inc_load=1 with inc_in < 2^(ACC_W-1): inc_in is written to the pending register and reload_pending is set.
  - inc_in ≥ 2^(ACC_W-1): the load is ignored and pending is unchanged, because two MSB edges per clk are impossible to track.
  - A second valid load before application overwrites pending. Last one wins.
  - Pending is applied on the clk edge where frame_start is asserted. inc ← pending, and reload_pending clears.
  - A load in the same cycle as a frame wrap is captured but applied at the next wrap. The wrap applies the older pending value, if any.
  - The accumulator is never cleared on reload. Phase stays continuous.
- Reset mid-operation: all state returns to reset values immediately, and any pending load is discarded.

## Timing

- Reset values:
  - acc = 0, mcnt = 0, inc = INC_RST.
  - mclk = sclk = lrck = 0.
  - mclk_tick = frame_start = reload_pending = 0.
- All outputs are flops. No combinational path from any input to any output.
- mclk, mclk_tick, sclk, lrck and frame_start all update on the same clk edge, the one that registers the tick. They are mutually aligned with zero skew.
- First MCLK rising edge from reset: ceil(2^(ACC_W-1)/INC) clk cycles after rst falls, with en=1 throughout.
- A reload applied at wrap edge N takes effect in the accumulation at edge N+1.
- MCLK period jitter is at most one clk period. This is accepted.

## Configuration

- AUDIO_CLKGEN_RELOAD_EN
  - Defined: runtime increment reload via pending register and frame-aligned application, as described under Operation.
  - Undefined: inc is fixed at INC_RST. inc_in and inc_load remain as ports but are ignored. reload_pending is tied to 0.

## Test plan

- Reset: assert rst asynchronously mid-frame. All outputs must read 0 before the next clk edge. After release, the first mclk_tick must occur after 5 clk cycles at the default INC.
- Rate: default parameters, en=1 for 100000 clk cycles from reset.
  - Expect 12287 or 12288 mclk_tick pulses.
  - Expect sclk to toggle every 2 ticks.
  - Expect lrck to toggle every 128 ticks.
  - Expect frame_start exactly once per 256 ticks, coincident with lrck falling.
- Reload (macro defined): load 2^30 at mcnt = 37.
  - reload_pending=1 until the next frame_start, then 0.
  - After that edge, mclk toggles every 2 clk cycles.
  - Loads 3×10^8 and then 4×10^8 before one wrap: only 4×10^8 is applied.
- Invalid and simultaneous loads:
  - Load 0x9000_0000: ignored, reload_pending stays 0.
  - Load 2^29 in the same cycle as frame_start: applied at the following wrap, not this one.
- Enable: drop en for 50 cycles mid-frame. acc, mcnt, mclk, sclk and lrck must hold; no ticks or frame_start during the gap. Cadence resumes from the held phase.
- Macro undefined: pulse inc_load with inc_in = 2^30. The rate must be unchanged and reload_pending must stay 0.
